// File: rtl/lane_match_flag_pipe_if.sv
// rtl/lane_match_flag_pipe_if.sv - input/output stream handshake bundle for lane_match_flag_pipe
interface lane_match_flag_pipe_if #(
  parameter int LANES  = 2,
  parameter int LANE_W = 16
);
  logic [LANES*LANE_W-1:0] din;
  logic                    din_vld;
  logic                    din_rd;
  logic                    dout_flag;
  logic [LANES-1:0]        dout_vec;
  logic                    dout_vld;
  logic                    dout_rd;

  modport master (
    output din, din_vld, dout_rd,
    input  din_rd, dout_flag, dout_vec, dout_vld
  );

  modport slave (
    input  din, din_vld, dout_rd,
    output din_rd, dout_flag, dout_vec, dout_vld
  );
endinterface

// File: rtl/lane_match_flag_pipe.sv
// rtl/lane_match_flag_pipe.sv - two-stage per-lane match, increment, bit-reverse flag pipeline
// Optional zero-flag statistics counter enabled by LANE_MATCH_STATS_EN.
module lane_match_flag_pipe #(
  parameter int          LANES     = 2,
  parameter int          LANE_W    = 16,
  parameter int unsigned MATCH_VAL = 1,
  parameter int          CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef LANE_MATCH_STATS_EN
  output logic [CNT_W-1:0]       stat_zero_cnt,
  input  logic                   stat_clr,
`endif
  lane_match_flag_pipe_if.slave  bus
);

  localparam logic [LANE_W-1:0] MATCH_L = LANE_W'(MATCH_VAL);

  if (LANES < 1 || LANE_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("lane_match_flag_pipe: LANES, LANE_W and CNT_W must be >= 1");
  end

  logic             r_s1_vld;
  logic [LANES-1:0] r_s1_m;
  logic             r_dout_vld;
  logic             r_dout_flag;
  logic [LANES-1:0] r_dout_vec;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [LANES-1:0] w_m;
  logic [LANES-1:0] w_s;
  logic [LANES-1:0] w_r;

  assign w_s2_adv   = !r_dout_vld || bus.dout_rd;
  assign w_s1_adv   = !r_s1_vld || w_s2_adv;
  assign bus.din_rd = w_s1_adv;

  always_comb begin
    w_m = '0;
    for (int i = 0; i < LANES; i++) begin
      w_m[i] = (bus.din[i*LANE_W +: LANE_W] == MATCH_L);
    end
  end

  // Carry out of the increment is dropped, so an all-match vector wraps to zero.
  assign w_s = r_s1_m + LANES'(1);

  always_comb begin
    w_r = '0;
    for (int i = 0; i < LANES; i++) begin
      w_r[i] = w_s[LANES-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_m      <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_flag <= 1'b0;
      r_dout_vec  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_dout_vld  <= r_s1_vld;
        r_dout_vec  <= w_r;
        r_dout_flag <= |w_r;
      end
      if (w_s1_adv) begin
        r_s1_vld <= bus.din_vld;
        r_s1_m   <= w_m;
      end
    end
  end

  assign bus.dout_vld  = r_dout_vld;
  assign bus.dout_flag = r_dout_flag;
  assign bus.dout_vec  = r_dout_vec;

`ifdef LANE_MATCH_STATS_EN
  logic [CNT_W-1:0] r_zero_cnt;

  // Clear wins over a same-cycle increment; the count saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_cnt <= '0;
    end else if (stat_clr) begin
      r_zero_cnt <= '0;
    end else if (r_dout_vld && bus.dout_rd && !r_dout_flag && (r_zero_cnt != '1)) begin
      r_zero_cnt <= r_zero_cnt + CNT_W'(1);
    end
  end

  assign stat_zero_cnt = r_zero_cnt;
`endif

endmodule

// File: doc/lane_match_flag_pipe.md
Name: lane_match_flag_pipe

Overview:
- Parametrised, pipelined successor to the two-lane "halves equal constant" flag generator.
- Splits an N*W-bit word into N lanes and compares each lane to MATCH_VAL, building an N-bit match vector m.
- Computes s = (m + 1) mod 2^N, then r = bit-reverse(s), and asserts flag = (r != 0).
- Sits between streaming producers/consumers behind a valid/ready handshake, with two register stages and full back-pressure.

Parameters:
- LANES, 2, number of lanes N (>= 1).
- LANE_W, 16, bits per lane W (>= 1).
- MATCH_VAL, 1, constant each lane is compared against, truncated to LANE_W bits.
- CNT_W, 16, width of the statistics counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  LANES*LANE_W  input word; lane i = din[i*LANE_W +: LANE_W].
- din_vld  in  1  input valid.
- din_rd  out  1  input ready.
- dout_flag  out  1  registered flag result.
- dout_vec  out  LANES  registered r (bit-reversed, incremented match vector).
- dout_vld  out  1  output valid.
- dout_rd  in  1  output ready.
- stat_zero_cnt  out  CNT_W  count of transferred outputs with flag=0 (only with LANE_MATCH_STATS_EN).
- stat_clr  in  1  synchronous clear of stat_zero_cnt (only with LANE_MATCH_STATS_EN).

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0: all valid bits are 0, dout_flag=0, dout_vec=0, stat_zero_cnt=0. din_rd=1 once out of reset.
- Transfer rule: a beat transfers when vld && rd on the same rising edge. Data must stay stable while vld=1 && rd=0. The block never drops or duplicates a beat.
- Stage 1 (s1):
  - Captures m[i] = (lane i == MATCH_VAL[LANE_W-1:0]) on an accepted input beat.
  - Sets s1_vld.
- Stage 2 (s2 = output registers):
  - s = m + 1, computed in LANES bits; carry out is discarded, so m = all-ones wraps to 0.
  - r[i] = s[LANES-1-i].
  - flag = OR-reduce(r), i.e. flag=0 iff every lane matched.
- Latency: 2 cycles from input transfer to dout_vld=1 when there is no stall. Throughput is 1 beat/cycle.
- Ready chain (combinational, no bubbles):
  - s2_adv = !dout_vld | dout_rd.
  - s1_adv = !s1_vld | s2_adv.
  - din_rd = s1_adv.
- s1 -> s2 move: when s2_adv, s2 loads s1 contents and dout_vld <= s1_vld.
- s1 load: when s1_adv, s1 loads din and s1_vld <= din_vld && din_rd.
- Stall: if dout_rd=0 with dout_vld=1, s2 holds. s1 also holds if valid. din_rd falls to 0 only when both stages are full.
- Simultaneous input accept and output drain: both happen in the same cycle; occupancy is unchanged.
- LANES=1: s = ~m, r = s, flag = ~m[0].
- Reset mid-operation: in-flight beats are discarded. After release, the output is silent until a new input is accepted.

Optional Feature:
- Macro: LANE_MATCH_STATS_EN.
- When defined:
  - Ports stat_zero_cnt and stat_clr exist.
  - The counter increments by 1 on each output transfer (dout_vld && dout_rd) with dout_flag=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - stat_clr=1 forces 0 next cycle and has priority over a simultaneous increment.
- When not defined:
  - The ports and counter logic are absent.
  - Datapath behaviour is identical in both cases.

Test Plan:
- Defaults; din=0x00010001, vld=1, dout_rd=1 -> 2 cycles later dout_vld=1, dout_vec=2'b00, dout_flag=0.
- Defaults; din=0x00000000 -> dout_vec=2'b10, dout_flag=1. din=0x00010000 (m=10, s=11) -> dout_vec=2'b11, flag=1.
- LANES=4, LANE_W=8, MATCH_VAL=0xAA; din=0xAA00AAAA (m=1011, s=1100, r=0011) -> dout_vec=4'b0011, flag=1.
- Back-pressure:
  - Stream 5 beats with dout_rd=0 -> din_rd drops after exactly 2 accepted beats.
  - Then dout_rd=1 -> all 5 results emerge in order, with no loss or duplication.
- Assert rst_n=0 for 1 cycle with both stages full -> dout_vld=0 immediately, and no stale beat appears afterwards.
- With LANE_MATCH_STATS_EN and CNT_W=2:
  - 4 all-match beats transferred -> stat_zero_cnt saturates at 3.
  - stat_clr pulsed together with a 5th all-match transfer -> counter reads 0.
